// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter: packet-based round-robin arbiter. It gives one output channel
// to N requesters by driving the select of a 2-to-1 mux tree.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous, active-high reset
//   req_i        per-requester beat valid
//   in_data_i    concatenated data, requester i at [i*DATA_W +: DATA_W]
//   in_last_i    per-requester last-beat flag (qualified by req_i)
//   in_ready_o   per-requester ready, one-hot or zero
//   out_data_o   data of the granted requester, zero when out_valid_o=0
//   out_last_o   last flag of the granted requester, zero when out_valid_o=0
//   out_valid_o  output beat valid
//   out_ready_i  consumer ready
//   sel_o        index of the granted requester (mux select)
//   busy_o       high while a grant is held
// ---------------------------------------------------------------------------

// Basic 2-to-1 mux cell: y = sel ? b : a
module mux2 #(
    parameter int W = 1
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

module mux_rr_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N-1:0]        req_i,
    input  logic [N*DATA_W-1:0] in_data_i,
    input  logic [N-1:0]        in_last_i,
    output logic [N-1:0]        in_ready_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic                out_last_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [SEL_W-1:0]    sel_o,
    output logic                busy_o
);
    localparam int LEAVES = 1 << SEL_W;
    localparam int MW     = DATA_W + 1;   // {last, data} travel together

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] pick;
    logic             found;
    logic             xfer_last;

    // ---------------- mux tree ----------------
    // Leaves padded to a power of two; padding leaves are zero and can never be
    // selected because sel only ever holds indices below N.
    logic [MW-1:0] leaf [LEAVES];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < N) begin : g_used
            assign leaf[i] = {in_last_i[i], in_data_i[i*DATA_W +: DATA_W]};
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    // Level L holds 2**L nodes. Level 0 is the root. Level L's nodes switch on
    // sel bit SEL_W-1-L, so the leaf reached is the one whose index equals sel.
    for (genvar L = SEL_W - 1; L >= 0; L--) begin : g_lvl
        logic [MW-1:0] nd [1 << L];
        for (genvar j = 0; j < (1 << L); j++) begin : g_node
            logic [MW-1:0] a, b;
            if (L == SEL_W - 1) begin : g_from_leaf
                assign a = leaf[2*j];
                assign b = leaf[2*j+1];
            end else begin : g_from_lvl
                assign a = g_lvl[L+1].nd[2*j];
                assign b = g_lvl[L+1].nd[2*j+1];
            end
            mux2 #(.W(MW)) u_mux (
                .sel_i (sel_q[SEL_W-1-L]),
                .a_i   (a),
                .b_i   (b),
                .y_o   (nd[j])
            );
        end
    end

    logic [MW-1:0] root;
    assign root = g_lvl[0].nd[0];

    // ---------------- outputs ----------------
    assign busy_o      = (state_q == BUSY);
    assign out_valid_o = busy_o & req_i[sel_q];
    assign out_data_o  = root[DATA_W-1:0] & {DATA_W{out_valid_o}};
    assign out_last_o  = root[DATA_W] & out_valid_o;
    assign sel_o       = sel_q;
    assign xfer_last   = out_valid_o & out_ready_i & out_last_o;

    always_comb begin
        in_ready_o = '0;
        if (state_q == BUSY) in_ready_o[sel_q] = out_ready_i;
    end

    // Rotating search: first set request at or above ptr, wrapping past N-1.
    always_comb begin
        pick  = sel_q;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            int               idx;
            logic [SEL_W-1:0] cand;
            idx = int'(ptr_q) + off;
            if (idx >= N) idx = idx - N;
            cand = SEL_W'(idx);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The grant is held until the last beat transfers, even if req drops.
                if (xfer_last) begin
                    state_d = IDLE;
                    ptr_d   = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
